// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI command sequencer / register file.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR,
        RD_TURN,
        RD,
        DROP
    } state_t;

    localparam logic [6:0] STATUS_BASE  = 7'b1010_010;
    localparam logic [7:0] DROP_BYTE    = 8'hFF;
    localparam int         CMD_RW_BIT   = 7;
    localparam int         CMD_ADDR_MSB = 6;

    function automatic logic [7:0] status_byte(input logic err);
        return {STATUS_BASE, err};
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_sync2.sv
// Two-flop synchronizer; resets to 1 so an idle (high) slave select is assumed.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command sequencer and register file: decodes framed read/write commands,
// performs auto-incrementing accesses and arbitrates against a core write port.
module spi_reg_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter  int REG_COUNT = 16,
    localparam int ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ss,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_in,
    output logic [7:0]             byte_out,
    input  logic                   lw_en,
    input  logic [ADDR_W-1:0]      lw_addr,
    input  logic [7:0]             lw_data,
    output logic                   lw_collide,
    output logic                   wr_stb,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [7:0]             wr_data,
    output logic [REG_COUNT*8-1:0] regs_q,
    output logic                   frame_active
);

    state_t            state, state_n;
    logic              ss_s;
    logic [1:0]        settle;
    logic              armed;
    logic              err, err_n;
    logic [ADDR_W-1:0] addr, addr_n, addr_inc;
    logic [7:0]        regs   [REG_COUNT];
    logic [7:0]        regs_n [REG_COUNT];
    logic              spi_we;
    logic              lw_ok, lw_hit, lw_drop;
    logic              cmd_read, cmd_bad;
    logic [7:0]        byte_out_n;
    logic              load_out;

    sync2 u_ss_sync (
        .clk (clk),
        .rst (rst),
        .d   (ss),
        .q   (ss_s)
    );

    // A frame may only begin once ss has been seen high after the synchronizer
    // settles, so a reset in mid-frame cannot resurrect the tail of that frame.
    assign frame_active = armed & ~ss_s;

    assign cmd_read = byte_in[CMD_RW_BIT];
    assign cmd_bad  = {1'b0, byte_in[CMD_ADDR_MSB:0]} >= 8'(REG_COUNT);
    assign addr_inc = (addr == ADDR_W'(REG_COUNT - 1)) ? '0 : addr + ADDR_W'(1);

    generate
        if (REG_COUNT == (1 << ADDR_W)) begin : g_full_range
            assign lw_ok = 1'b1;
        end else begin : g_part_range
            assign lw_ok = ({1'b0, lw_addr} < (ADDR_W + 1)'(REG_COUNT));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (frame_active) state_n = CMD;
            CMD: begin
                if (byte_valid) begin
                    if (cmd_bad)       state_n = DROP;
                    else if (cmd_read) state_n = RD_TURN;
                    else               state_n = WR;
                end
            end
            RD_TURN: if (byte_valid) state_n = RD;
            default: ;
        endcase
        if (ss_s) state_n = IDLE;
    end

    // The byte is always processed before a coincident frame end takes effect.
    always_comb begin
        err_n  = err;
        addr_n = addr;
        spi_we = 1'b0;
        if (byte_valid) begin
            case (state)
                CMD: begin
                    err_n  = cmd_bad;
                    addr_n = byte_in[ADDR_W-1:0];
                end
                WR: begin
                    spi_we = 1'b1;
                    addr_n = addr_inc;
                end
                RD:      addr_n = addr_inc;
                default: ;
            endcase
        end

        lw_hit  = lw_en && lw_ok;
        lw_drop = lw_hit && spi_we && (lw_addr == addr);

        regs_n = regs;
        if (lw_hit && !lw_drop) regs_n[lw_addr] = lw_data;
        if (spi_we)             regs_n[addr]    = byte_in;

        case (state_n)
            DROP:    byte_out_n = DROP_BYTE;
            RD:      byte_out_n = regs_n[addr_n];
            default: byte_out_n = status_byte(err_n);
        endcase
        load_out = (state_n != state) || (byte_valid && (state != IDLE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle     <= 2'b00;
            armed      <= 1'b0;
            err        <= 1'b0;
            addr       <= '0;
            wr_stb     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'h00;
            lw_collide <= 1'b0;
            byte_out   <= status_byte(1'b0);
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'h00;
        end else begin
            settle     <= {settle[0], 1'b1};
            if (settle[1] && ss_s) armed <= 1'b1;
            err        <= err_n;
            addr       <= addr_n;
            regs       <= regs_n;
            wr_stb     <= spi_we;
            lw_collide <= lw_drop;
            if (spi_we) begin
                wr_addr <= addr;
                wr_data <= byte_in;
            end
            if (load_out) byte_out <= byte_out_n;
        end
    end

    generate
        for (genvar i = 0; i < REG_COUNT; i++) begin : g_flat
            assign regs_q[8*i +: 8] = regs[i];
        end
    endgenerate

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: table-driven frames plus hand-written
// collision and reset sequences, with a write scoreboard.
module tb_spi_reg_ctrl;

    localparam int REG_COUNT = 16;
    localparam int ADDR_W    = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   ss;
    logic                   byte_valid;
    logic [7:0]             byte_in;
    logic [7:0]             byte_out;
    logic                   lw_en;
    logic [ADDR_W-1:0]      lw_addr;
    logic [7:0]             lw_data;
    logic                   lw_collide;
    logic                   wr_stb;
    logic [ADDR_W-1:0]      wr_addr;
    logic [7:0]             wr_data;
    logic [REG_COUNT*8-1:0] regs_q;
    logic                   frame_active;

    spi_reg_ctrl #(.REG_COUNT(REG_COUNT)) dut (
        .clk          (clk),
        .rst          (rst),
        .ss           (ss),
        .byte_valid   (byte_valid),
        .byte_in      (byte_in),
        .byte_out     (byte_out),
        .lw_en        (lw_en),
        .lw_addr      (lw_addr),
        .lw_data      (lw_data),
        .lw_collide   (lw_collide),
        .wr_stb       (wr_stb),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .regs_q       (regs_q),
        .frame_active (frame_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    typedef struct {
        bit                start;
        bit                stop;
        logic [7:0]        mosi;
        bit                expWr;
        logic [ADDR_W-1:0] wAddr;
        logic [7:0]        wData;
        logic [7:0]        expMiso;
        logic [7:0]        expIdle;
    } vec_t;

    wr_t  expWrites[$];
    vec_t vecs[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(bit st, bit sp, logic [7:0] m, bit w,
                                logic [ADDR_W-1:0] a, logic [7:0] d,
                                logic [7:0] miso, logic [7:0] idle);
        vec_t v;
        v.start = st;  v.stop = sp;   v.mosi = m;       v.expWr = w;
        v.wAddr = a;   v.wData = d;   v.expMiso = miso; v.expIdle = idle;
        return v;
    endfunction

    task automatic expectWrite(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        expWrites.push_back(w);
    endtask

    // One byte-completion pulse, optionally with a simultaneous core write.
    task automatic applyStimulus(input logic [7:0] b, input logic le,
                                 input logic [ADDR_W-1:0] la, input logic [7:0] ld);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        lw_en      = le;
        lw_addr    = la;
        lw_data    = ld;
        @(negedge clk);
        byte_valid = 1'b0;
        lw_en      = 1'b0;
    endtask

    task automatic startFrame(input logic expActive);
        @(negedge clk);
        ss = 1'b0;
        @(negedge clk);
        checkOutput("frame_active_after_1clk", 128'(frame_active), 128'(1'b0));
        @(negedge clk);
        checkOutput("frame_active_after_2clk", 128'(frame_active), 128'(expActive));
    endtask

    task automatic endFrame(input logic [7:0] expIdle);
        @(negedge clk);
        ss = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("byte_out_idle", 128'(byte_out), 128'(expIdle));
        checkOutput("frame_active_idle", 128'(frame_active), 128'(1'b0));
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (wr_stb) begin
            if (expWrites.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         wr_addr, wr_data);
            end else begin
                e = expWrites.pop_front();
                checkOutput("wr_addr", 128'(wr_addr), 128'(e.addr));
                checkOutput("wr_data", 128'(wr_data), 128'(e.data));
            end
        end
    end

    initial begin
        logic [127:0] expImg;

        rst = 1'b1;  ss = 1'b1;  byte_valid = 1'b0;  byte_in = 8'h00;
        lw_en = 1'b0;  lw_addr = '0;  lw_data = 8'h00;

        // write 03/11/22, read back, wrap write at 15, wrap read, bad command, recovery
        vecs.push_back(mk(1, 0, 8'h03, 0, 4'h0, 8'h00, 8'hA4, 8'h00));
        vecs.push_back(mk(0, 0, 8'h11, 1, 4'h3, 8'h11, 8'hA4, 8'h00));
        vecs.push_back(mk(0, 1, 8'h22, 1, 4'h4, 8'h22, 8'hA4, 8'hA4));
        vecs.push_back(mk(1, 0, 8'h83, 0, 4'h0, 8'h00, 8'hA4, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 8'h11, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 8'h22, 8'h00));
        vecs.push_back(mk(0, 1, 8'h00, 0, 4'h0, 8'h00, 8'h00, 8'hA4));
        vecs.push_back(mk(1, 0, 8'h0F, 0, 4'h0, 8'h00, 8'hA4, 8'h00));
        vecs.push_back(mk(0, 0, 8'h5A, 1, 4'hF, 8'h5A, 8'hA4, 8'h00));
        vecs.push_back(mk(0, 1, 8'h6B, 1, 4'h0, 8'h6B, 8'hA4, 8'hA4));
        vecs.push_back(mk(1, 0, 8'h8F, 0, 4'h0, 8'h00, 8'hA4, 8'h00));
        vecs.push_back(mk(0, 0, 8'hFF, 0, 4'h0, 8'h00, 8'h5A, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 8'h6B, 8'h00));
        vecs.push_back(mk(0, 1, 8'h00, 0, 4'h0, 8'h00, 8'h00, 8'hA4));
        vecs.push_back(mk(1, 0, 8'h20, 0, 4'h0, 8'h00, 8'hFF, 8'h00));
        vecs.push_back(mk(0, 0, 8'h77, 0, 4'h0, 8'h00, 8'hFF, 8'h00));
        vecs.push_back(mk(0, 1, 8'h88, 0, 4'h0, 8'h00, 8'hFF, 8'hA5));
        vecs.push_back(mk(1, 0, 8'h80, 0, 4'h0, 8'h00, 8'hA4, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 8'h6B, 8'h00));
        vecs.push_back(mk(0, 1, 8'h00, 0, 4'h0, 8'h00, 8'h00, 8'hA4));

        repeat (2) @(negedge clk);
        checkOutput("reset_byte_out", 128'(byte_out), 128'(8'hA4));
        checkOutput("reset_regs_q", regs_q, 128'(0));
        checkOutput("reset_wr_stb", 128'(wr_stb), 128'(1'b0));
        checkOutput("reset_wr_addr", 128'(wr_addr), 128'(0));
        checkOutput("reset_wr_data", 128'(wr_data), 128'(0));
        checkOutput("reset_lw_collide", 128'(lw_collide), 128'(1'b0));
        checkOutput("reset_frame_active", 128'(frame_active), 128'(1'b0));
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].start) startFrame(1'b1);
            if (vecs[i].expWr) expectWrite(vecs[i].wAddr, vecs[i].wData);
            applyStimulus(vecs[i].mosi, 1'b0, '0, 8'h00);
            checkOutput($sformatf("miso_vec%0d", i), 128'(byte_out), 128'(vecs[i].expMiso));
            if (vecs[i].stop) endFrame(vecs[i].expIdle);
        end

        expImg = '0;
        expImg[8*0 +: 8]  = 8'h6B;
        expImg[8*3 +: 8]  = 8'h11;
        expImg[8*4 +: 8]  = 8'h22;
        expImg[8*15 +: 8] = 8'h5A;
        checkOutput("regs_after_table", regs_q, expImg);

        // core write colliding with SPI on the same address: SPI wins
        startFrame(1'b1);
        applyStimulus(8'h05, 1'b0, '0, 8'h00);
        expectWrite(4'h5, 8'hAB);
        applyStimulus(8'hAB, 1'b1, 4'h5, 8'hCD);
        checkOutput("lw_collide_pulse", 128'(lw_collide), 128'(1'b1));
        @(negedge clk);
        checkOutput("lw_collide_cleared", 128'(lw_collide), 128'(1'b0));
        endFrame(8'hA4);
        checkOutput("collide_reg5", 128'(regs_q[8*5 +: 8]), 128'(8'hAB));

        // core write to a different address proceeds alongside SPI
        startFrame(1'b1);
        applyStimulus(8'h05, 1'b0, '0, 8'h00);
        expectWrite(4'h5, 8'h3C);
        applyStimulus(8'h3C, 1'b1, 4'h6, 8'h9D);
        checkOutput("no_collide", 128'(lw_collide), 128'(1'b0));
        endFrame(8'hA4);
        checkOutput("parallel_reg5", 128'(regs_q[8*5 +: 8]), 128'(8'h3C));
        checkOutput("parallel_reg6", 128'(regs_q[8*6 +: 8]), 128'(8'h9D));

        @(negedge clk);
        lw_en = 1'b1;  lw_addr = 4'h7;  lw_data = 8'hE1;
        @(negedge clk);
        lw_en = 1'b0;
        checkOutput("core_only_reg7", 128'(regs_q[8*7 +: 8]), 128'(8'hE1));

        // reset in the middle of a write frame
        startFrame(1'b1);
        applyStimulus(8'h08, 1'b0, '0, 8'h00);
        expectWrite(4'h8, 8'h44);
        applyStimulus(8'h44, 1'b0, '0, 8'h00);
        checkOutput("pre_reset_reg8", 128'(regs_q[8*8 +: 8]), 128'(8'h44));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_regs_q", regs_q, 128'(0));
        checkOutput("midrst_byte_out", 128'(byte_out), 128'(8'hA4));
        checkOutput("midrst_wr_addr", 128'(wr_addr), 128'(0));
        checkOutput("midrst_wr_data", 128'(wr_data), 128'(0));
        checkOutput("midrst_frame_active", 128'(frame_active), 128'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h55, 1'b0, '0, 8'h00);
        applyStimulus(8'h66, 1'b0, '0, 8'h00);
        checkOutput("postrst_frame_active", 128'(frame_active), 128'(1'b0));
        checkOutput("postrst_regs_q", regs_q, 128'(0));
        checkOutput("postrst_byte_out", 128'(byte_out), 128'(8'hA4));
        endFrame(8'hA4);

        startFrame(1'b1);
        applyStimulus(8'h02, 1'b0, '0, 8'h00);
        expectWrite(4'h2, 8'h99);
        applyStimulus(8'h99, 1'b0, '0, 8'h00);
        endFrame(8'hA4);
        expImg = '0;
        expImg[8*2 +: 8] = 8'h99;
        checkOutput("recovered_regs_q", regs_q, expImg);

        checkOutput("pending_writes", 128'(expWrites.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
